mem_access_unit: RTL and testbench

Memory-stage load/store unit for the 5-stage RV32I pipeline, sitting directly downstream of the EX_MEM pipeline register and upstream of MEM_WB. It replaces the single-cycle data array with a request/acknowledge data bus. It handles byte-lane steering, load sign/zero extension, alignment checking and bus timeouts. It holds the pipeline through `stall_o` while an access is outstanding.

---
 rtl/mem_access_unit_if.sv | 34 +++
 rtl/mem_access_unit.sv | 216 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Request/acknowledge data bus between the memory-stage load/store unit and data memory.
// The master issues a held request; the slave answers with a single-cycle ack or err.
interface mem_access_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_be,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata,
        input  bus_err
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_be,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata,
        output bus_err
    );
endinterface

// File: rtl/mem_access_unit.sv
// Purpose: RV32I memory-stage load/store unit driving a req/ack data bus (lane steering, extension, faults).
// Latency: 3 cycles best case (IDLE, WAIT+ack, DONE); faults without bus use take 2 cycles.
// Backpressure: holds the pipeline via stall_o while an access is pending; bus wait bounded by TIMEOUT_CYCLES.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        exc_o,
    output logic [1:0]  exc_cause_o,
    mem_access_unit_if.master bus
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] CAUSE_MISALIGN = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
    localparam logic [1:0] CAUSE_BUS_ERR  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;

    logic        req_q, req_nxt;
    logic        we_q, we_nxt;
    logic [31:0] addr_q, addr_nxt;
    logic [3:0]  be_q, be_nxt;
    logic [31:0] wdata_q, wdata_nxt;
    logic [31:0] rdata_q, rdata_nxt;
    logic        exc_q, exc_nxt;
    logic [1:0]  cause_q, cause_nxt;
    logic        stall;

    logic        access;
    logic        illegal;
    logic        misaligned;
    logic [3:0]  be_dec;
    logic [31:0] wdata_dec;
    logic [4:0]  lane_shift;
    logic [31:0] lane_word;
    logic [31:0] load_val;

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    assign access = mem_read_i | mem_write_i;

    // funct3[1:0]: 00 byte, 01 half, otherwise word.
    assign illegal = (mem_read_i & mem_write_i)
                   | (mem_read_i  & ((funct3_i == 3'b011) | (funct3_i[2:1] == 2'b11)))
                   | (mem_write_i & funct3_i[2]);

    assign misaligned = ((funct3_i[1:0] == 2'b01) & addr_i[0])
                      | (funct3_i[1] & (addr_i[1:0] != 2'b00));

    always_comb begin
        be_dec    = 4'b1111;
        wdata_dec = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                be_dec    = 4'b0001 << addr_i[1:0];
                wdata_dec = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_dec    = 4'b0011 << addr_i[1:0];
                wdata_dec = {2{wdata_i[15:0]}};
            end
            default: begin
                be_dec    = 4'b1111;
                wdata_dec = wdata_i;
            end
        endcase
    end

    // Addressed lane moved to bit 0; a halfword is already known aligned here.
    assign lane_shift = {addr_i[1:0], 3'b000};
    assign lane_word  = bus.bus_rdata >> lane_shift;

    always_comb begin
        load_val = lane_word;
        case (funct3_i)
            3'b000:  load_val = {{24{lane_word[7]}},  lane_word[7:0]};
            3'b001:  load_val = {{16{lane_word[15]}}, lane_word[15:0]};
            3'b100:  load_val = {24'd0, lane_word[7:0]};
            3'b101:  load_val = {16'd0, lane_word[15:0]};
            default: load_val = bus.bus_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_nxt   = req_q;
        we_nxt    = we_q;
        addr_nxt  = addr_q;
        be_nxt    = be_q;
        wdata_nxt = wdata_q;
        rdata_nxt = rdata_q;
        exc_nxt   = exc_q;
        cause_nxt = cause_q;
        stall     = 1'b0;

        case (state)
            IDLE: begin
                if (access) begin
                    stall     = 1'b1;
                    rdata_nxt = 32'd0;
                    exc_nxt   = 1'b0;
                    if (illegal) begin
                        exc_nxt   = 1'b1;
                        cause_nxt = CAUSE_ILLEGAL;
                        state_nxt = DONE;
                    end else if (misaligned) begin
                        exc_nxt   = 1'b1;
                        cause_nxt = CAUSE_MISALIGN;
                        state_nxt = DONE;
                    end else begin
                        req_nxt   = 1'b1;
                        we_nxt    = mem_write_i;
                        addr_nxt  = {addr_i[31:2], 2'b00};
                        be_nxt    = be_dec;
                        wdata_nxt = wdata_dec;
                        cnt_nxt   = 8'd0;
                        state_nxt = WAIT;
                    end
                end
            end

            WAIT: begin
                stall   = 1'b1;
                cnt_nxt = cnt + 8'd1;
                // err beats ack, ack beats a timeout landing on the same cycle
                if (bus.bus_err) begin
                    req_nxt   = 1'b0;
                    exc_nxt   = 1'b1;
                    cause_nxt = CAUSE_BUS_ERR;
                    state_nxt = DONE;
                end else if (bus.bus_ack) begin
                    req_nxt   = 1'b0;
                    rdata_nxt = mem_read_i ? load_val : 32'd0;
                    state_nxt = DONE;
                end else if (cnt == CNT_LAST) begin
                    req_nxt   = 1'b0;
                    exc_nxt   = 1'b1;
                    cause_nxt = CAUSE_TIMEOUT;
                    state_nxt = DONE;
                end
            end

            DONE: begin
                exc_nxt   = 1'b0;
                rdata_nxt = 32'd0;
                state_nxt = IDLE;
            end

            default: begin
                req_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            exc_q   <= 1'b0;
            cause_q <= 2'b00;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            req_q   <= req_nxt;
            we_q    <= we_nxt;
            addr_q  <= addr_nxt;
            be_q    <= be_nxt;
            wdata_q <= wdata_nxt;
            rdata_q <= rdata_nxt;
            exc_q   <= exc_nxt;
            cause_q <= cause_nxt;
        end
    end

    // Gated by reset so the pipeline is released the instant reset asserts.
    assign stall_o       = stall & reset;
    assign rdata_o       = rdata_q;
    assign exc_o         = exc_q;
    assign exc_cause_o   = cause_q;
    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: a transaction-level model predicts stall length,
// bus fields and load result/exception for each access, and a scripted slave answers the bus.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        exc_o;
    logic [1:0]  exc_cause_o;

    int n_chk = 0;
    int n_bad = 0;

    mem_access_unit_if bus ();

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_read_i  (mem_read_i),
        .mem_write_i (mem_write_i),
        .funct3_i    (funct3_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .stall_o     (stall_o),
        .rdata_o     (rdata_o),
        .exc_o       (exc_o),
        .exc_cause_o (exc_cause_o),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One instruction through MEM. Call just after a negedge; returns just after the
    // negedge following DONE (unit back in IDLE). ack_lat/err_lat count WAIT cycles from 1; 0 = never.
    task automatic do_access(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rword,
                             input int ack_lat, input int err_lat);
        int          wsz, k, stalls, reqs;
        bit          ill, mis, done, seen;
        logic [3:0]  e_be;
        logic [31:0] e_wd, e_rd, lane, mask;
        logic        e_exc;
        logic [1:0]  e_cause;

        // ---- reference model ----
        wsz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        ill  = (rd && wr) || (rd && (f3 == 3 || f3 == 6 || f3 == 7)) || (wr && f3[2]);
        mis  = (addr % wsz) != 0;
        e_be = 4'(((1 << wsz) - 1) << (addr % 4));
        for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = wd[8*(i % wsz) +: 8];
        e_rd = 32'd0; e_exc = 1'b0; e_cause = 2'b00; k = 0;
        if (ill) begin
            e_exc = 1'b1; e_cause = 2'b01;
        end else if (mis) begin
            e_exc = 1'b1; e_cause = 2'b00;
        end else begin
            k = TO;
            for (int i = 1; i <= TO; i++)
                if (i == ack_lat || i == err_lat) begin k = i; break; end
            if (k == err_lat) begin
                e_exc = 1'b1; e_cause = 2'b10;
            end else if (k == ack_lat) begin
                if (rd) begin
                    lane = rword >> (8 * (addr % 4));
                    if (wsz == 4) e_rd = lane;
                    else begin
                        mask = (wsz == 1) ? 32'hFF : 32'hFFFF;
                        e_rd = lane & mask;
                        if (!f3[2] && e_rd[8*wsz-1]) e_rd = e_rd | ~mask;
                    end
                end
            end else begin
                e_exc = 1'b1; e_cause = 2'b11;
            end
        end

        // ---- drive and observe ----
        mem_read_i = rd; mem_write_i = wr; funct3_i = f3; addr_i = addr; wdata_i = wd;
        stalls = 0; reqs = 0; done = 0; seen = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (!stall_o) done = 1;
            else begin
                stalls++;
                if (bus.bus_req) begin
                    reqs++;
                    if (!seen) begin
                        seen = 1;
                        check_eq({nm, " addr"}, bus.bus_addr, {addr[31:2], 2'b00});
                        check_eq({nm, " be"}, 32'(bus.bus_be), 32'(e_be));
                        check_eq({nm, " we"}, 32'(bus.bus_we), 32'(wr));
                        if (wr) check_eq({nm, " wdata"}, bus.bus_wdata, e_wd);
                    end
                    bus.bus_ack   = (reqs == ack_lat);
                    bus.bus_err   = (reqs == err_lat);
                    bus.bus_rdata = (reqs == ack_lat) ? rword : $urandom;
                end else begin
                    bus.bus_ack = 1'b0;
                    bus.bus_err = 1'b0;
                end
                @(negedge clk);
            end
        end
        bus.bus_ack = 1'b0;
        bus.bus_err = 1'b0;
        check_eq({nm, " reached done"}, 32'(done), 32'd1);
        check_eq({nm, " stall cycles"}, stalls, 1 + k);
        check_eq({nm, " req cycles"}, reqs, k);
        check_eq({nm, " req low in done"}, 32'(bus.bus_req), 32'd0);
        check_eq({nm, " rdata"}, rdata_o, e_rd);
        check_eq({nm, " exc"}, 32'(exc_o), 32'(e_exc));
        if (e_exc) check_eq({nm, " cause"}, 32'(exc_cause_o), 32'(e_cause));
        @(negedge clk);
        check_eq({nm, " exc pulse ended"}, 32'(exc_o), 32'd0);
    endtask

    task automatic idle_gap(input int n);
        mem_read_i = 1'b0; mem_write_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            check_eq("idle stall", 32'(stall_o), 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        logic       rd, wr;
        logic [2:0] f3;
        int         al, el;

        reset = 1'b0;
        mem_read_i = 1'b0; mem_write_i = 1'b0; funct3_i = 3'd0; addr_i = 32'd0; wdata_i = 32'd0;
        bus.bus_ack = 1'b0; bus.bus_err = 1'b0; bus.bus_rdata = 32'd0;
        repeat (2) @(negedge clk);
        check_eq("rst stall", 32'(stall_o), 32'd0);
        check_eq("rst req", 32'(bus.bus_req), 32'd0);
        check_eq("rst we", 32'(bus.bus_we), 32'd0);
        check_eq("rst be", 32'(bus.bus_be), 32'd0);
        check_eq("rst addr", bus.bus_addr, 32'd0);
        check_eq("rst wdata", bus.bus_wdata, 32'd0);
        check_eq("rst rdata", rdata_o, 32'd0);
        check_eq("rst exc", 32'(exc_o), 32'd0);
        check_eq("rst cause", 32'(exc_cause_o), 32'd0);
        reset = 1'b1;
        idle_gap(2);

        // Directed cases
        do_access("lw_10",    1, 0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1, 0);
        do_access("lb_13",    1, 0, 3'b000, 32'h13, 32'h0, 32'h8012_3456, 3, 0);
        do_access("lbu_13",   1, 0, 3'b100, 32'h13, 32'h0, 32'h8012_3456, 3, 0);
        do_access("sh_22",    0, 1, 3'b001, 32'h22, 32'h1234_ABCD, 32'h5555_5555, 2, 0);
        do_access("lw_mis",   1, 0, 3'b010, 32'h05, 32'h0, 32'h0, 1, 0);
        do_access("ld_ill",   1, 0, 3'b011, 32'h08, 32'h0, 32'h0, 1, 0);
        do_access("rw_ill",   1, 1, 3'b010, 32'h08, 32'h0, 32'h0, 1, 0);
        do_access("lw_tmo",   1, 0, 3'b010, 32'h40, 32'h0, 32'h0, 0, 0);
        do_access("tmo_ack",  1, 0, 3'b010, 32'h44, 32'h0, 32'hCAFE_F00D, TO, 0);
        do_access("err_ack",  1, 0, 3'b010, 32'h48, 32'h0, 32'h1111_2222, 2, 2);
        idle_gap(1);

        // Reset while waiting on the bus
        mem_read_i = 1'b1; mem_write_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h80;
        repeat (2) @(negedge clk);
        #1;
        check_eq("pre-rst req", 32'(bus.bus_req), 32'd1);
        reset = 1'b0;
        #1;
        check_eq("async rst req", 32'(bus.bus_req), 32'd0);
        check_eq("async rst stall", 32'(stall_o), 32'd0);
        mem_read_i = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        bus.bus_ack = 1'b1; bus.bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.bus_ack = 1'b0;
        check_eq("late ack req", 32'(bus.bus_req), 32'd0);
        check_eq("late ack stall", 32'(stall_o), 32'd0);
        check_eq("late ack rdata", rdata_o, 32'd0);
        check_eq("late ack exc", 32'(exc_o), 32'd0);
        do_access("post_rst", 1, 0, 3'b001, 32'h86, 32'h0, 32'h8001_7FFF, 1, 0);

        // Randomized traffic, back-to-back or with idle gaps
        for (int t = 0; t < 200; t++) begin
            int sel;
            sel = $urandom_range(0, 19);
            rd  = (sel < 10) || (sel == 19);
            wr  = (sel >= 10);
            f3  = 3'($urandom_range(0, 7));
            if (wr && !rd && f3 == 3'b011) f3 = 3'b010;
            al  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, TO + 2);
            el  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, TO) : 0;
            do_access("rand", rd, wr, f3, {24'h0, 8'($urandom)}, $urandom, $urandom, al, el);
            if ($urandom_range(0, 2) == 0) idle_gap($urandom_range(1, 2));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
